// File: rtl/sb_mac16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sb_mac16_pkg
// Desc     : Select encodings, widths and the 8x8 multiply helper for sb_mac16.
// Revision : 1.0 - initial release
// ============================================================================
package sb_mac16_pkg;

  localparam int c_BYTE_W = 8;
  localparam int c_HALF_W = 16;
  localparam int c_FULL_W = 32;

  localparam logic UPPER_Q  = 1'b0;
  localparam logic UPPER_CD = 1'b1;

  localparam logic [1:0] LOWER_AB    = 2'b00;
  localparam logic [1:0] LOWER_8X8   = 2'b01;
  localparam logic [1:0] LOWER_16X16 = 2'b10;
  localparam logic [1:0] LOWER_ZERO  = 2'b11;

  localparam logic [1:0] CARRY_0       = 2'b00;
  localparam logic [1:0] CARRY_1       = 2'b01;
  localparam logic [1:0] CARRY_CASCADE = 2'b10;
  localparam logic [1:0] CARRY_CI      = 2'b11;

  localparam logic [1:0] OUT_SUM   = 2'b00;
  localparam logic [1:0] OUT_ACC   = 2'b01;
  localparam logic [1:0] OUT_8X8   = 2'b10;
  localparam logic [1:0] OUT_16X16 = 2'b11;

  // Each byte is widened to 9 bits so one signed multiply covers every signedness mix.
  function automatic logic signed [17:0] mulExt(input logic [7:0] a, input logic aSgn,
                                                input logic [7:0] b, input logic bSgn);
    logic signed [8:0] ax;
    logic signed [8:0] bx;
    ax = {aSgn & a[7], a};
    bx = {bSgn & b[7], b};
    return ax * bx;
  endfunction

endpackage : sb_mac16_pkg
`default_nettype wire

// File: rtl/sb_mac16_addsub.sv
`default_nettype none
// ============================================================================
// Module   : sb_mac16_addsub
// Desc     : One 16-bit half of the MAC16 adder: operand/carry muxing, add or
//            subtract, accumulator half and output select.
// Revision : 1.0 - initial release
// ============================================================================
module sb_mac16_addsub
  import sb_mac16_pkg::*;
#(
  parameter logic       UPPER_INPUT   = UPPER_Q,
  parameter logic [1:0] LOWER_INPUT   = LOWER_AB,
  parameter logic [1:0] CARRY_SELECT  = CARRY_0,
  parameter logic [1:0] OUTPUT_SELECT = OUT_SUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CE,
  input  logic [c_HALF_W-1:0] cdIn,
  input  logic [c_HALF_W-1:0] abIn,
  input  logic [c_HALF_W-1:0] mult8In,
  input  logic [c_HALF_W-1:0] mult16In,
  input  logic                cascadeIn,
  input  logic                CI,
  input  logic                addSub,
  input  logic                oHold,
  input  logic                oLoad,
  output logic                co,
  output logic [c_HALF_W-1:0] out
);

  logic [c_HALF_W-1:0] r_acc;
  logic [c_HALF_W-1:0] w_upper;
  logic [c_HALF_W-1:0] w_lower;
  logic                w_cin;
  logic [c_HALF_W:0]   w_sum17;

  always_comb begin
    w_upper = (UPPER_INPUT == UPPER_CD) ? cdIn : r_acc;
    case (LOWER_INPUT)
      LOWER_AB:    w_lower = abIn;
      LOWER_8X8:   w_lower = mult8In;
      LOWER_16X16: w_lower = mult16In;
      default:     w_lower = '0;
    endcase
    case (CARRY_SELECT)
      CARRY_0:       w_cin = 1'b0;
      CARRY_1:       w_cin = 1'b1;
      CARRY_CASCADE: w_cin = cascadeIn;
      default:       w_cin = CI;
    endcase
    // Bit 16 is the carry on add and the borrow on subtract.
    if (addSub)
      w_sum17 = {1'b0, w_upper} - {1'b0, w_lower} - {{c_HALF_W{1'b0}}, w_cin};
    else
      w_sum17 = {1'b0, w_upper} + {1'b0, w_lower} + {{c_HALF_W{1'b0}}, w_cin};
  end

  assign co = w_sum17[c_HALF_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_acc <= '0;
    else if (CE && !oHold)
      r_acc <= oLoad ? cdIn : w_sum17[c_HALF_W-1:0];
  end

  always_comb begin
    case (OUTPUT_SELECT)
      OUT_SUM: out = w_sum17[c_HALF_W-1:0];
      OUT_ACC: out = r_acc;
      OUT_8X8: out = mult8In;
      default: out = mult16In;
    endcase
  end

endmodule : sb_mac16_addsub
`default_nettype wire

// File: rtl/sb_mac16.sv
`default_nettype none
// ============================================================================
// Module   : sb_mac16
// Desc     : 16x16 multiply/add/accumulate slice, iCE40 MAC16 compatible.
//            Optional input/pipeline registers exist only when
//            SB_MAC16_PIPELINE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sb_mac16
  import sb_mac16_pkg::*;
#(
  parameter int         A_SIGNED                 = 0,
  parameter int         B_SIGNED                 = 0,
  parameter int         MODE_8x8                 = 0,
  parameter int         A_REG                    = 0,
  parameter int         B_REG                    = 0,
  parameter int         C_REG                    = 0,
  parameter int         D_REG                    = 0,
  parameter int         TOP_8x8_MULT_REG         = 0,
  parameter int         BOT_8x8_MULT_REG         = 0,
  parameter int         PIPELINE_16x16_MULT_REG1 = 0,
  parameter int         PIPELINE_16x16_MULT_REG2 = 0,
  parameter logic       TOPADDSUB_UPPERINPUT     = 1'b0,
  parameter logic [1:0] TOPADDSUB_LOWERINPUT     = 2'b00,
  parameter logic [1:0] TOPADDSUB_CARRYSELECT    = 2'b00,
  parameter logic [1:0] TOPOUTPUT_SELECT         = 2'b00,
  parameter logic       BOTADDSUB_UPPERINPUT     = 1'b0,
  parameter logic [1:0] BOTADDSUB_LOWERINPUT     = 2'b00,
  parameter logic [1:0] BOTADDSUB_CARRYSELECT    = 2'b00,
  parameter logic [1:0] BOTOUTPUT_SELECT         = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CE,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  input  logic [15:0] D,
  input  logic        AHOLD,
  input  logic        BHOLD,
  input  logic        CHOLD,
  input  logic        DHOLD,
  input  logic        OHOLDTOP,
  input  logic        OHOLDBOT,
  input  logic        OLOADTOP,
  input  logic        OLOADBOT,
  input  logic        ADDSUBTOP,
  input  logic        ADDSUBBOT,
  input  logic        CI,
  output logic        CO,
  output logic [31:0] O
);

`ifdef SB_MAC16_PIPELINE_EN
  localparam bit c_PIPE_EN = 1'b1;
`else
  localparam bit c_PIPE_EN = 1'b0;
`endif

  localparam bit c_A_REG   = c_PIPE_EN && (A_REG != 0);
  localparam bit c_B_REG   = c_PIPE_EN && (B_REG != 0);
  localparam bit c_C_REG   = c_PIPE_EN && (C_REG != 0);
  localparam bit c_D_REG   = c_PIPE_EN && (D_REG != 0);
  localparam bit c_F_REG   = c_PIPE_EN && (TOP_8x8_MULT_REG != 0);
  localparam bit c_J_REG   = c_PIPE_EN && (BOT_8x8_MULT_REG != 0);
  localparam bit c_PP_REG  = c_PIPE_EN && (PIPELINE_16x16_MULT_REG1 != 0);
  localparam bit c_P_REG   = c_PIPE_EN && (PIPELINE_16x16_MULT_REG2 != 0);
  localparam bit c_A_SGN   = (A_SIGNED != 0);
  localparam bit c_B_SGN   = (B_SIGNED != 0);
  localparam bit c_MODE8   = (MODE_8x8 != 0);
  localparam logic [3:0] c_IN_REG = {c_D_REG, c_C_REG, c_B_REG, c_A_REG};
  localparam int c_PP_W    = 2 * c_HALF_W + 36;

  logic [3:0][c_HALF_W-1:0] w_inRaw;
  logic [3:0][c_HALF_W-1:0] w_in;
  logic [3:0]               w_inHold;
  logic [c_HALF_W-1:0]      w_a, w_b, w_c, w_d;

  assign w_inRaw  = {D, C, B, A};
  assign w_inHold = {DHOLD, CHOLD, BHOLD, AHOLD};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_in
      if (c_IN_REG[gi]) begin : g_reg
        logic [c_HALF_W-1:0] r_val;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)
            r_val <= '0;
          else if (CE && !w_inHold[gi])
            r_val <= w_inRaw[gi];
        end
        assign w_in[gi] = r_val;
      end else begin : g_pass
        assign w_in[gi] = w_inRaw[gi];
      end
    end
  endgenerate

  assign {w_d, w_c, w_b, w_a} = w_in;

  // Low bytes are only signed when the slice runs as two independent 8x8s.
  logic signed [17:0] w_fFull, w_jFull, w_kFull, w_gFull;
  logic [c_HALF_W-1:0] w_f, w_j, w_fOut, w_jOut;

  assign w_fFull = mulExt(w_a[15:8], c_A_SGN, w_b[15:8], c_B_SGN);
  assign w_jFull = mulExt(w_a[7:0], c_MODE8 & c_A_SGN, w_b[7:0], c_MODE8 & c_B_SGN);
  assign w_kFull = mulExt(w_a[15:8], c_A_SGN, w_b[7:0], 1'b0);
  assign w_gFull = mulExt(w_a[7:0], 1'b0, w_b[15:8], c_B_SGN);
  assign w_f     = w_fFull[c_HALF_W-1:0];
  assign w_j     = w_jFull[c_HALF_W-1:0];

  generate
    if (c_F_REG) begin : g_fReg
      logic [c_HALF_W-1:0] r_f;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    r_f <= '0;
        else if (CE) r_f <= w_f;
      end
      assign w_fOut = r_f;
    end else begin : g_fPass
      assign w_fOut = w_f;
    end

    if (c_J_REG) begin : g_jReg
      logic [c_HALF_W-1:0] r_j;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    r_j <= '0;
        else if (CE) r_j <= w_j;
      end
      assign w_jOut = r_j;
    end else begin : g_jPass
      assign w_jOut = w_j;
    end
  endgenerate

  logic [c_PP_W-1:0]   w_ppRaw, w_pp;
  logic [c_HALF_W-1:0] w_fPp, w_jPp;
  logic [17:0]         w_kPp, w_gPp;
  logic [c_FULL_W-1:0] w_pRaw, w_pFull, w_p;

  assign w_ppRaw = {w_f, w_j, w_kFull, w_gFull};

  generate
    if (c_PP_REG) begin : g_ppReg
      logic [c_PP_W-1:0] r_pp;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    r_pp <= '0;
        else if (CE) r_pp <= w_ppRaw;
      end
      assign w_pp = r_pp;
    end else begin : g_ppPass
      assign w_pp = w_ppRaw;
    end
  endgenerate

  assign {w_fPp, w_jPp, w_kPp, w_gPp} = w_pp;
  // Cross terms are sign-extended so the 32-bit sum is exact for any signedness.
  assign w_pRaw = {w_fPp, 16'h0000}
                + (({{14{w_kPp[17]}}, w_kPp} + {{14{w_gPp[17]}}, w_gPp}) << 8)
                + {16'h0000, w_jPp};

  generate
    if (c_P_REG) begin : g_pReg
      logic [c_FULL_W-1:0] r_p;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    r_p <= '0;
        else if (CE) r_p <= w_pRaw;
      end
      assign w_pFull = r_p;
    end else begin : g_pPass
      assign w_pFull = w_pRaw;
    end
  endgenerate

  assign w_p = c_MODE8 ? '0 : w_pFull;

  logic                w_botCo;
  logic [c_HALF_W-1:0] w_topOut, w_botOut;

  sb_mac16_addsub #(
    .UPPER_INPUT  (BOTADDSUB_UPPERINPUT),
    .LOWER_INPUT  (BOTADDSUB_LOWERINPUT),
    .CARRY_SELECT (BOTADDSUB_CARRYSELECT),
    .OUTPUT_SELECT(BOTOUTPUT_SELECT)
  ) u_bot (
    .clk(clk), .rst(rst), .CE(CE),
    .cdIn(w_d), .abIn(w_b), .mult8In(w_jOut), .mult16In(w_p[15:0]),
    .cascadeIn(CI), .CI(CI), .addSub(ADDSUBBOT),
    .oHold(OHOLDBOT), .oLoad(OLOADBOT),
    .co(w_botCo), .out(w_botOut)
  );

  sb_mac16_addsub #(
    .UPPER_INPUT  (TOPADDSUB_UPPERINPUT),
    .LOWER_INPUT  (TOPADDSUB_LOWERINPUT),
    .CARRY_SELECT (TOPADDSUB_CARRYSELECT),
    .OUTPUT_SELECT(TOPOUTPUT_SELECT)
  ) u_top (
    .clk(clk), .rst(rst), .CE(CE),
    .cdIn(w_c), .abIn(w_a), .mult8In(w_fOut), .mult16In(w_p[31:16]),
    .cascadeIn(w_botCo), .CI(CI), .addSub(ADDSUBTOP),
    .oHold(OHOLDTOP), .oLoad(OLOADTOP),
    .co(CO), .out(w_topOut)
  );

  assign O = {w_topOut, w_botOut};

  // Hold inputs and the widened product top bits are dead in some builds.
  logic w_unused;
  assign w_unused = ^{w_inHold, w_fFull[17:16], w_jFull[17:16]};

endmodule : sb_mac16
`default_nettype wire

// File: tb/tb_sb_mac16.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_mac16
// Desc     : Directed self-checking bench for sb_mac16 (add/sub, multiply,
//            accumulate, async reset, input-register latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_mac16;

`ifdef SB_MAC16_PIPELINE_EN
  localparam bit PIPE_BUILD = 1'b1;
`else
  localparam bit PIPE_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, CE, CI;
  logic [15:0] A, B, C, D;
  logic        AHOLD, BHOLD, CHOLD, DHOLD;
  logic        OHOLDTOP, OHOLDBOT, OLOADTOP, OLOADBOT, ADDSUBTOP, ADDSUBBOT;

  logic [31:0] oAdd, oMulU, oMulS, oAcc, oPipe;
  logic        coAdd, coMulU, coMulS, coAcc, coPipe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sb_mac16 #(
    .TOPADDSUB_UPPERINPUT(1'b1), .TOPADDSUB_LOWERINPUT(2'b00),
    .TOPADDSUB_CARRYSELECT(2'b10), .TOPOUTPUT_SELECT(2'b00),
    .BOTADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_LOWERINPUT(2'b00),
    .BOTADDSUB_CARRYSELECT(2'b10), .BOTOUTPUT_SELECT(2'b00)
  ) dutAdd (
    .clk(clk), .rst(rst), .CE(CE), .A(A), .B(B), .C(C), .D(D),
    .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .CO(coAdd), .O(oAdd)
  );

  sb_mac16 #(
    .TOPOUTPUT_SELECT(2'b11), .BOTOUTPUT_SELECT(2'b11)
  ) dutMulU (
    .clk(clk), .rst(rst), .CE(CE), .A(A), .B(B), .C(C), .D(D),
    .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .CO(coMulU), .O(oMulU)
  );

  sb_mac16 #(
    .A_SIGNED(1), .B_SIGNED(1),
    .TOPOUTPUT_SELECT(2'b11), .BOTOUTPUT_SELECT(2'b11)
  ) dutMulS (
    .clk(clk), .rst(rst), .CE(CE), .A(A), .B(B), .C(C), .D(D),
    .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .CO(coMulS), .O(oMulS)
  );

  sb_mac16 #(
    .TOPADDSUB_UPPERINPUT(1'b0), .TOPADDSUB_LOWERINPUT(2'b10),
    .TOPADDSUB_CARRYSELECT(2'b10), .TOPOUTPUT_SELECT(2'b01),
    .BOTADDSUB_UPPERINPUT(1'b0), .BOTADDSUB_LOWERINPUT(2'b10),
    .BOTADDSUB_CARRYSELECT(2'b00), .BOTOUTPUT_SELECT(2'b01)
  ) dutAcc (
    .clk(clk), .rst(rst), .CE(CE), .A(A), .B(B), .C(C), .D(D),
    .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .CO(coAcc), .O(oAcc)
  );

  sb_mac16 #(
    .A_REG(1), .B_REG(1),
    .TOPOUTPUT_SELECT(2'b11), .BOTOUTPUT_SELECT(2'b11)
  ) dutPipe (
    .clk(clk), .rst(rst), .CE(CE), .A(A), .B(B), .C(C), .D(D),
    .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .CO(coPipe), .O(oPipe)
  );

  typedef struct {
    logic [15:0] a, b, c, d;
    logic        sub;
    logic [31:0] expAdd;
    logic        expCo;
    logic [31:0] expMulU;
    logic [31:0] expMulS;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          a        b        c        d        sub   add           co    mulU          mulS
    vecs[0] = '{16'h0000, 16'h0001, 16'h0001, 16'hFFFF, 1'b0, 32'h00020000, 1'b0, 32'h00000000, 32'h00000000};
    vecs[1] = '{16'h0000, 16'h0001, 16'h0001, 16'h0000, 1'b1, 32'h0000FFFF, 1'b0, 32'h00000000, 32'h00000000};
    vecs[2] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFE0001, 32'h00000001};
    vecs[4] = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 1'b0, 32'hFFFF0002, 1'b0, 32'h0001FFFE, 32'hFFFFFFFE};
    vecs[5] = '{16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF, 1'b0, 32'h12345677, 1'b1, 32'h06260060, 32'h06260060};
    vecs[6] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 1'b1, 32'h7FFF8001, 1'b1, 32'h3FFF8000, 32'hC0008000};

    rst = 1'b0; CE = 1'b0; CI = 1'b0;
    A = '0; B = '0; C = '0; D = '0;
    AHOLD = 0; BHOLD = 0; CHOLD = 0; DHOLD = 0;
    OHOLDTOP = 0; OHOLDBOT = 0; OLOADTOP = 0; OLOADBOT = 0;
    ADDSUBTOP = 0; ADDSUBBOT = 0;

    #2;
    check("reset_acc_O", oAcc, 32'h0);
    check("reset_add_O", oAdd, 32'h0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      A = vecs[i].a; B = vecs[i].b; C = vecs[i].c; D = vecs[i].d;
      ADDSUBTOP = vecs[i].sub; ADDSUBBOT = vecs[i].sub;
      #2;
      check($sformatf("vec%0d_add_O", i), oAdd, vecs[i].expAdd);
      check($sformatf("vec%0d_add_CO", i), {31'b0, coAdd}, {31'b0, vecs[i].expCo});
      check($sformatf("vec%0d_mulU_O", i), oMulU, vecs[i].expMulU);
      check($sformatf("vec%0d_mulS_O", i), oMulS, vecs[i].expMulS);
    end

    // Accumulate 3*4 per clock
    ADDSUBTOP = 0; ADDSUBBOT = 0;
    A = 16'd3; B = 16'd4; C = '0; D = '0;
    tick();
    CE = 1'b1;
    tick(); check("acc_step1", oAcc, 32'd12);
    tick(); check("acc_step2", oAcc, 32'd24);
    tick(); check("acc_step3", oAcc, 32'd36);
    OHOLDTOP = 1; OHOLDBOT = 1;
    tick(); check("acc_ohold", oAcc, 32'd36);
    OHOLDTOP = 0; OHOLDBOT = 0;
    OLOADTOP = 1; OLOADBOT = 1; C = 16'd0; D = 16'd100;
    tick(); check("acc_oload", oAcc, 32'd100);
    OLOADTOP = 0; OLOADBOT = 0;
    tick(); check("acc_after_load", oAcc, 32'd112);
    CE = 1'b0;
    tick(); check("acc_ce_low", oAcc, 32'd112);
    CE = 1'b1;

    // Asynchronous reset between edges
    #2; rst = 1'b0;
    #1; check("acc_async_rst", oAcc, 32'h0);
    #1; rst = 1'b1;
    tick(); check("acc_restart", oAcc, 32'd12);
    check("pipe_settled", oPipe, 32'd12);

    // Input-register latency
    A = 16'd5; B = 16'd6;
    #1; check("pipe_before_edge", oPipe, PIPE_BUILD ? 32'd12 : 32'd30);
    tick(); check("pipe_after_edge", oPipe, 32'd30);
    check("acc_new_product", oAcc, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sb_mac16
`default_nettype wire

// File: doc/sb_mac16.md
Name: sb_mac16

Overview:
- 16x16 multiply/add/accumulate DSP slice, behaviourally compatible with the iCE40 MAC16 primitive.
- Used by alu32 for 32-bit add/sub (adders only) and for the 4-step 32-bit multiply (16x16 product plus accumulate).
- Datapath: optional input registers, one 16x16 multiplier (or two 8x8), a top and a bottom 16-bit adder/subtractor, a 32-bit accumulator register and an output mux.

Parameters:
- A_SIGNED, 0: A operand is two's-complement.
- B_SIGNED, 0: B operand is two's-complement.
- MODE_8x8, 0: 1 means two independent 8x8 products; the 16x16 path is unused.
- A_REG, B_REG, C_REG, D_REG, 0: register the corresponding input.
- TOP_8x8_MULT_REG, BOT_8x8_MULT_REG, 0: register F or J.
- PIPELINE_16x16_MULT_REG1, 0: register the partial products.
- PIPELINE_16x16_MULT_REG2, 0: register P.
- TOPADDSUB_UPPERINPUT, 0: top adder upper input. 0 = Q[31:16], 1 = C.
- TOPADDSUB_LOWERINPUT, 2'b00: top adder lower input. 00 = A, 01 = F, 10 = P[31:16], 11 = 16'h0000.
- TOPADDSUB_CARRYSELECT, 2'b00: top carry-in. 00 = 0, 01 = 1, 10 = bottom carry-out, 11 = CI.
- TOPOUTPUT_SELECT, 2'b00: O[31:16] source. 00 = top sum (combinational), 01 = Q[31:16], 10 = F, 11 = P[31:16].
- BOTADDSUB_UPPERINPUT, BOTADDSUB_LOWERINPUT, BOTADDSUB_CARRYSELECT, BOTOUTPUT_SELECT: bottom equivalents. Sources are Q[15:0], D, B, J, P[15:0]. Carry select 10 and 11 both mean CI.

Ports:
- clk in 1: rising-edge clock for every register.
- rst in 1: asynchronous, active-low; clears all registers.
- CE in 1: global clock enable for all registers.
- A, B, C, D in 16 each: operands.
- AHOLD, BHOLD, CHOLD, DHOLD in 1 each: hold the corresponding input register.
- OHOLDTOP, OHOLDBOT in 1: hold Q top/bottom.
- OLOADTOP, OLOADBOT in 1: load C (top) / D (bottom) into Q.
- ADDSUBTOP, ADDSUBBOT in 1: 0 = add, 1 = subtract.
- CI in 1: cascade carry in.
- CO out 1: top adder carry/borrow out.
- O out 32: {top, bottom} result.

Behaviour:
- Reset (rst=0, asynchronous):
  - Input registers, pipeline registers and Q all go to 0.
  - O follows its mux; O = 0 for output select 01.
- Register update: only when CE=1 and the matching HOLD is 0. Unregistered stages are pass-through (0-cycle).
- Partial products:
  - F = A[15:8]*B[15:8], J = A[7:0]*B[7:0], K = A[15:8]*B[7:0], G = A[7:0]*B[15:8].
  - Upper bytes are signed per A_SIGNED/B_SIGNED; lower bytes are always unsigned.
- 16x16 product: P = (F<<16) + ((K+G)<<8) + J, computed as 32 bits. With both signed, the result is the exact signed product.
- MODE_8x8=1: F and J are computed as full 8x8 products (signed per A_SIGNED/B_SIGNED); P is forced to 0.
- Adders:
  - Add: sum = U + L + cin; carry-out = bit 16.
  - Subtract: sum = U − L − cin; carry-out = borrow.
  - With bottom cin=0 and top cin = bottom carry-out, the pair forms an exact 32-bit add/sub of {C,D} ± {A,B}, wrapping modulo 2^32.
- Accumulator Q (per half, on clock):
  - OLOAD=1: Q ← C / D.
  - Otherwise Q ← sum.
  - OHOLD has priority over OLOAD.
- CO = top adder carry-out, combinational.
- Latency from A/B to O[*] = number of enabled register stages on that path.
- Reset asserted mid-accumulation clears Q immediately; accumulation restarts from 0 after release.

Optional Feature:
- SB_MAC16_PIPELINE_EN defined: all *_REG and pipeline parameters are honoured.
- Undefined:
  - Those registers are not generated and their parameters are ignored (treated as 0).
  - Only Q remains sequential.
  - Parameter values that request registers produce no error.

Decomposition:
- Package sb_mac16_pkg holds:
  - Select encodings (UPPER_Q/UPPER_CD, LOWER_AB/LOWER_8X8/LOWER_16X16/LOWER_ZERO, CARRY_0/1/CASCADE/CI, OUT_SUM/OUT_ACC/OUT_8X8/OUT_16X16).
  - Width constants.
- One natural sub-module: sb_mac16_addsub. It is a 16-bit add/sub with upper/lower/carry muxing and an accumulator half, instantiated twice (top and bottom).

Test Plan:
- 32-bit add (alu32 config: upper=1, lower=00, bottom carry=10 with CI=0, top carry=10, out=00):
  - C,D = 0x0001,0xFFFF; A,B = 0x0000,0x0001; ADDSUB=0 → O = 0x00020000.
- Same config, subtract: {C,D}=0x00010000, {A,B}=0x00000001, ADDSUB=1 → O = 0x0000FFFF; {C,D}=0, {A,B}=1 → O = 0xFFFFFFFF.
- Unsigned 16x16 with output select 11: A=0xFFFF, B=0xFFFF → O = 0xFFFE0001.
- A_SIGNED=B_SIGNED=1: A=0xFFFF, B=0x0002 → O = 0xFFFFFFFE.
- Accumulate (upper=0, lower=10, out=01, bottom carry=00, top carry=10):
  - A=3, B=4, CE=1 → O = 12, 24, 36 on successive clocks.
  - OHOLD=1 keeps 36.
  - OLOAD with C,D = 0,100 → next O = 100.
- Pulse rst=0 between clock edges mid-accumulation → O = 0 immediately, without waiting for a clock edge. With SB_MAC16_PIPELINE_EN and A_REG=B_REG=1, product output appears one cycle after the input changes.
